// File: rtl/clk_meter_pkg.sv
// rtl/clk_meter_pkg.sv - shared defaults and state encoding for the clock ratio meter
package clk_meter_pkg;

  localparam int CNT_W_DEF  = 8;
  localparam int LOCK_N_DEF = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_t;

endpackage

// File: rtl/sig_sync.sv
// rtl/sig_sync.sv - two-flop synchronizer plus edge register producing a rising-edge strobe
module sig_sync (
  input  logic clkin,
  input  logic rst_n,
  input  logic sig_in,
  output logic level,
  output logic rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // shift the asynchronous input through two metastability flops and one history flop
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign level = r_s2;
  assign rise  = r_s2 & ~r_s3;

endmodule

// File: rtl/clk_ratio_meter.sv
// rtl/clk_ratio_meter.sv - measures sig_in period and duty in clkin cycles with lock and timeout flags
module clk_ratio_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int LOCK_N = LOCK_N_DEF
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] ratio,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  localparam int                LW       = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [LW-1:0]     LOCK_SAT = LW'(LOCK_N);
  localparam logic [LW-1:0]     LOCK_HIT = LW'(LOCK_N - 1);

  logic             w_level;
  logic             w_rise;
  logic             w_match;
  logic [LW-1:0]    w_lock_next;

  meter_state_t     r_state;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_hi;
  logic [LW-1:0]    r_lock_cnt;
  logic             r_have_ref;
  logic [CNT_W-1:0] r_ratio;
  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] r_low;
  logic             r_valid;
  logic             r_locked;
  logic             r_timeout;

  sig_sync u_sync (
    .clkin  (clkin),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .level  (w_level),
    .rise   (w_rise)
  );

  // a period only matches when a prior measurement from the same run exists
  assign w_match     = r_have_ref && (r_period == r_ratio);
  assign w_lock_next = (r_lock_cnt == LOCK_SAT) ? LOCK_SAT : r_lock_cnt + LW'(1);

  // measurement state machine: count the period, publish on rise, drop to IDLE on starvation
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_period   <= '0;
      r_hi       <= '0;
      r_lock_cnt <= '0;
      r_have_ref <= 1'b0;
      r_ratio    <= '0;
      r_high     <= '0;
      r_low      <= '0;
      r_valid    <= 1'b0;
      r_locked   <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state    <= MEASURE;
            r_period   <= CNT_ONE;
            r_hi       <= CNT_ONE;
            r_timeout  <= 1'b0;
            r_have_ref <= 1'b0;
          end
        end
        MEASURE: begin
          if (w_rise) begin
            // a rise on the saturation cycle still completes the measurement
            r_ratio    <= r_period;
            r_high     <= r_hi;
            r_low      <= r_period - r_hi;
            r_valid    <= 1'b1;
            r_period   <= CNT_ONE;
            r_hi       <= CNT_ONE;
            r_have_ref <= 1'b1;
            if (w_match) begin
              r_lock_cnt <= w_lock_next;
              if (w_lock_next >= LOCK_HIT) begin
                r_locked <= 1'b1;
              end
            end else begin
              r_lock_cnt <= '0;
              r_locked   <= 1'b0;
            end
          end else if (r_period == CNT_MAX) begin
            r_timeout  <= 1'b1;
            r_locked   <= 1'b0;
            r_lock_cnt <= '0;
            r_have_ref <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_period <= r_period + CNT_ONE;
            r_hi     <= r_hi + CNT_W'(w_level);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ratio    = r_ratio;
  assign high_cnt = r_high;
  assign low_cnt  = r_low;
  assign valid    = r_valid;
  assign locked   = r_locked;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// tb/tb_clk_ratio_meter.sv - randomized self-checking bench for clk_ratio_meter
module tb_clk_ratio_meter;

  localparam int CNT_W  = 8;
  localparam int LOCK_N = 4;
  localparam int TMO    = (1 << CNT_W) - 1;

  logic             clkin  = 1'b0;
  logic             rst_n  = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] ratio;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic             valid;
  logic             locked;
  logic             timeout;

  clk_ratio_meter #(.CNT_W(CNT_W), .LOCK_N(LOCK_N)) dut (
    .clkin    (clkin),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .ratio    (ratio),
    .high_cnt (high_cnt),
    .low_cnt  (low_cnt),
    .valid    (valid),
    .locked   (locked),
    .timeout  (timeout)
  );

  always #5 clkin = ~clkin;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: per-cycle synchronized level history, periods from rise indices
  bit   m_d1, m_lvl, m_lvl_prev, m_meas;
  bit   hist[$];
  int   cyc, m_p, m_last, m_run, m_per, m_hi;
  int   e_ratio = 0, e_high = 0, e_low = 0;
  bit   e_valid = 0, e_locked = 0, e_timeout = 0;

  initial forever begin
    @(posedge clkin or negedge rst_n);
    if (!rst_n) begin
      m_d1 = 0; m_lvl = 0; m_lvl_prev = 0; m_meas = 0;
      hist.delete();
      cyc = 0; m_p = 0; m_last = 0; m_run = 0;
      e_ratio = 0; e_high = 0; e_low = 0;
      e_valid = 0; e_locked = 0; e_timeout = 0;
    end else begin
      e_valid = 0;
      if (m_lvl && !m_lvl_prev) begin
        if (m_meas) begin
          m_per = cyc - m_p;
          m_hi  = 0;
          for (int i = m_p; i < cyc; i++) m_hi += int'(hist[i]);
          e_ratio = m_per;
          e_high  = m_hi;
          e_low   = m_per - m_hi;
          e_valid = 1;
          m_run    = (m_run > 0 && m_per == m_last) ? m_run + 1 : 1;
          m_last   = m_per;
          e_locked = (m_run >= LOCK_N);
        end else begin
          m_meas    = 1;
          e_timeout = 0;
          m_run     = 0;
        end
        m_p = cyc;
      end else if (m_meas && (cyc - m_p) == TMO) begin
        e_timeout = 1;
        e_locked  = 0;
        m_meas    = 0;
        m_run     = 0;
      end
      hist.push_back(m_lvl);
      cyc++;
      m_lvl_prev = m_lvl;
      m_lvl      = m_d1;
      m_d1       = sig_in;
    end
  end

  // compare process plus event monitors used by the literal expectations
  int ncyc = 0, n_valid = 0, last_valid_cyc = 0, tmo_cyc = 0;
  int watch = 0, n_watch = 0, lock_at = 0;
  bit lock_seen = 0, first_watch_locked = 1, prev_locked = 0, prev_tmo = 0;

  initial forever begin
    @(negedge clkin);
    check("valid",    int'(valid),    int'(e_valid));
    check("ratio",    int'(ratio),    e_ratio);
    check("high_cnt", int'(high_cnt), e_high);
    check("low_cnt",  int'(low_cnt),  e_low);
    check("locked",   int'(locked),   int'(e_locked));
    check("timeout",  int'(timeout),  int'(e_timeout));
    ncyc++;
    if (valid) begin
      n_valid++;
      last_valid_cyc = ncyc;
      if (int'(ratio) == watch) begin
        n_watch++;
        if (n_watch == 1) first_watch_locked = locked;
      end
    end
    if (locked && !prev_locked && !lock_seen) begin
      lock_seen = 1;
      lock_at   = n_watch;
    end
    if (timeout && !prev_tmo) tmo_cyc = ncyc;
    prev_locked = locked;
    prev_tmo    = timeout;
  end

  task automatic per(input int hi, input int lo);
    sig_in = 1'b1;
    repeat (hi) @(negedge clkin);
    sig_in = 1'b0;
    repeat (lo) @(negedge clkin);
  endtask

  task automatic arm(input int r);
    watch = r; n_watch = 0; lock_seen = 0; lock_at = 0; first_watch_locked = 1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ratio"},   int'(ratio),    0);
    check({tag, "_high"},    int'(high_cnt), 0);
    check({tag, "_low"},     int'(low_cnt),  0);
    check({tag, "_valid"},   int'(valid),    0);
    check({tag, "_locked"},  int'(locked),   0);
    check({tag, "_timeout"}, int'(timeout),  0);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(negedge clkin);
    rst_n = 1'b1;
  endtask

  int vcount;
  bit got_tmo;

  initial begin
    repeat (3) @(negedge clkin);
    check_zero("por");
    rst_n = 1'b1;

    // divide-by-4, 50% duty
    arm(4);
    repeat (8) per(2, 2);
    repeat (4) @(negedge clkin);
    check("div4_lock_at", lock_at, 4);
    check("div4_ratio", int'(ratio), 4);
    check("div4_high", int'(high_cnt), 2);
    check("div4_low", int'(low_cnt), 2);

    // divide-by-3
    arm(3);
    repeat (8) per(2, 1);
    repeat (4) @(negedge clkin);
    check("div3_ratio", int'(ratio), 3);
    check("div3_sum", int'(high_cnt) + int'(low_cnt), 3);
    check("div3_high_ok", int'(high_cnt == 1 || high_cnt == 2), 1);
    check("div3_lock_at", lock_at, 4);

    // relock at 4 then switch to 6
    repeat (6) per(2, 2);
    check("pre6_locked", int'(locked), 1);
    arm(6);
    repeat (7) per(3, 3);
    repeat (4) @(negedge clkin);
    check("sw6_first_locked", int'(first_watch_locked), 0);
    check("sw6_lock_at", lock_at, 4);
    check("sw6_ratio", int'(ratio), 6);
    check("sw6_high", int'(high_cnt), 3);

    // starvation timeout and recovery
    repeat (6) per(2, 2);
    check("pre_tmo_locked", int'(locked), 1);
    vcount  = n_valid;
    got_tmo = 0;
    for (int i = 0; i < 400 && !got_tmo; i++) begin
      @(negedge clkin);
      #1 got_tmo = timeout;
    end
    check("tmo_seen", int'(got_tmo), 1);
    check("tmo_gap", tmo_cyc - last_valid_cyc, TMO);
    check("tmo_locked", int'(locked), 0);
    check("tmo_novalid", n_valid - vcount, 0);
    repeat (5) @(negedge clkin);
    vcount = n_valid;
    per(2, 2);
    check("tmo_clear", int'(timeout), 0);
    check("tmo_first_rise_novalid", n_valid - vcount, 0);
    repeat (5) per(2, 2);
    check("tmo_resume_ratio", int'(ratio), 4);

    // boundaries: minimum ratio, saturation coincident with rise, one past saturation
    repeat (6) per(1, 1);
    check("min_ratio", int'(ratio), 2);
    per(1, 254);
    per(1, 254);
    check("sat_ratio", int'(ratio), 255);
    check("sat_timeout", int'(timeout), 0);
    per(1, 255);
    repeat (4) per(2, 2);

    // randomized periods with occasional mid-period resets
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 14) == 0) begin
        sig_in = 1'($urandom_range(0, 1));
        @(negedge clkin);
        pulse_reset();
      end
      per($urandom_range(1, 6), $urandom_range(1, 6));
    end

    // reset mid-period while locked
    repeat (6) per(2, 2);
    check("pre_rst_locked", int'(locked), 1);
    sig_in = 1'b1;
    @(negedge clkin);
    pulse_reset();
    vcount = n_valid;
    sig_in = 1'b0;
    repeat (2) @(negedge clkin);
    per(2, 2);
    check("rst_one_rise_novalid", n_valid - vcount, 0);
    repeat (6) per(2, 2);
    check("rst_relock", int'(locked), 1);

    repeat (4) @(negedge clkin);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_ratio_meter.md
CLK_RATIO_METER -- requirements
Module: clk_ratio_meter

Interface
REQ-001 Parameter CNT_W, default 8: width of all period/phase counters and result outputs.
REQ-002 Parameter LOCK_N, default 4: consecutive equal periods required to assert locked.
REQ-003 clkin  input  1  reference clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 sig_in  input  1  divided/asynchronous clock under measurement (e.g. output of a divide-by-N block).
REQ-006 ratio  output  CNT_W  last measured period of sig_in, in clkin cycles (rising edge to rising edge).
REQ-007 high_cnt  output  CNT_W  clkin cycles sig_in was sampled high in the last period.
REQ-008 low_cnt  output  CNT_W  clkin cycles sig_in was sampled low in the last period; high_cnt+low_cnt = ratio.
REQ-009 valid  output  1  one-cycle pulse when ratio/high_cnt/low_cnt are updated.
REQ-010 locked  output  1  level; LOCK_N consecutive identical periods measured.
REQ-011 timeout  output  1  level; no sig_in rising edge for 2^CNT_W-1 cycles.

Function
REQ-012 sig_in SHALL pass a 2-flop synchronizer (s1, s2) plus a third register s3; rise = s2 & ~s3.
REQ-013 States SHALL be IDLE (await first rise) and MEASURE; reset enters IDLE.
REQ-014 IDLE: on rise -> MEASURE, period_cnt := 1, hi_acc := 1; no valid pulse.
REQ-015 MEASURE, no rise: period_cnt += 1 (saturating); hi_acc += 1 when s2 = 1.
REQ-016 MEASURE, rise: next cycle ratio := period_cnt, high_cnt := hi_acc, low_cnt := period_cnt - hi_acc, valid = 1 for exactly one cycle; period_cnt := 1, hi_acc := 1.
REQ-017 Latency: valid SHALL assert on the clkin edge after the cycle in which rise is high; synchronizer adds 2-3 cycles from sig_in edge to rise.
REQ-018 Minimum measurable ratio SHALL be 2; results are unsigned CNT_W-bit, no wrap.
REQ-019 If period_cnt reaches 2^CNT_W-1 in MEASURE: timeout := 1, locked := 0, lock_cnt := 0, state := IDLE, no valid pulse; ratio/high_cnt/low_cnt hold last values.
REQ-020 timeout SHALL clear on the next rise (same cycle state leaves IDLE).
REQ-021 Lock: on each valid update, if new ratio equals previous ratio, lock_cnt += 1 (saturate at LOCK_N), else lock_cnt := 0 and locked := 0; locked := 1 when lock_cnt reaches LOCK_N-1 matches after the first measurement (i.e. LOCK_N equal consecutive periods).
REQ-022 The first measurement after IDLE SHALL never match (no previous reference).
REQ-023 Rise coincident with saturation SHALL be treated as a rise (measurement wins over timeout).

Reset
REQ-024 rst_n low SHALL immediately force: s1=s2=s3=0, state IDLE, period_cnt=hi_acc=lock_cnt=0, ratio=high_cnt=low_cnt=0, valid=0, locked=0, timeout=0.
REQ-025 Reset asserted mid-measurement SHALL discard the partial period; first valid after release requires two rises.

Structure
REQ-026 Package clk_meter_pkg SHALL hold CNT_W/LOCK_N defaults and the state encoding constants (IDLE, MEASURE).
REQ-027 Sub-module sig_sync SHALL implement the synchronizer and rise detector (ports clkin, rst_n, sig_in, level, rise).
REQ-028 Implementation size target 120-400 lines; no multiply/divide logic.

Verification
REQ-029 sig_in = clkin/4, 50% duty -> after 2nd rise valid pulses every 4 cycles with ratio=4, high_cnt=2, low_cnt=2; locked=1 after 4th valid.
REQ-030 sig_in = 50%-duty divide-by-3 (pos|neg style) -> ratio=3, high_cnt+low_cnt=3, high_cnt in {1,2}, locked=1 after 4 valid.
REQ-031 Locked at ratio 4, switch source to ratio 6 -> first valid with ratio=6 drops locked; locked re-asserts on 4th consecutive ratio=6.
REQ-032 Locked at ratio 4, hold sig_in constant -> timeout=1 and locked=0 exactly 255 cycles after last rise; no valid; resume ratio 4 -> timeout clears on first rise, first valid on second rise.
REQ-033 Assert rst_n low mid-period while locked -> all outputs 0 asynchronously; after release, no valid until two rises seen.
